// File: rtl/config_sequencer_if.sv
// Control/status bundle between the power-up sequencer and the system side.
// The sequencer uses the slave modport; the system/board side uses master.
interface config_sequencer_if;
    logic       start;
    logic       cdce_done;
    logic       afe_done;
    logic       pll_lock;
    logic       cdce_enable;
    logic       cdce_reset_n;
    logic       afe_enable;
    logic       afe_reset_n;
    logic       config_done;
    logic       config_error;
    logic       lock_lost;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    modport slave (
        input  start, cdce_done, afe_done, pll_lock,
        output cdce_enable, cdce_reset_n, afe_enable, afe_reset_n,
        output config_done, config_error, lock_lost, retry_count, state_dbg
    );

    modport master (
        output start, cdce_done, afe_done, pll_lock,
        input  cdce_enable, cdce_reset_n, afe_enable, afe_reset_n,
        input  config_done, config_error, lock_lost, retry_count, state_dbg
    );
endinterface

// File: rtl/config_sequencer.sv
// Board power-up sequencer: POR delay, CDCE bring-up, PLL lock qualification,
// AFE bring-up, with timeout-driven retries and a terminal error state.
module config_sequencer #(
    parameter int unsigned POR_DELAY   = 1000,
    parameter int unsigned TIMEOUT     = 65535,
    parameter int unsigned LOCK_STABLE = 256,
    parameter int unsigned RETRY_HOLD  = 4,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned CNT_W       = 16
) (
    input logic              clk,
    input logic              reset_n,
    config_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] PorLast     = CNT_W'(POR_DELAY - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(RETRY_HOLD - 1);
    localparam logic [1:0]       MaxRetry    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPorWait  = 3'd1,
        StCdceRun  = 3'd2,
        StLockWait = 3'd3,
        StAfeRun   = 3'd4,
        StDone     = 3'd5,
        StRetry    = 3'd6,
        StError    = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic [1:0]       retry_q, retry_d;
    logic             exhaust_q, exhaust_d;
    logic             lock_lost_q, lock_lost_d;
    logic             sync1_q, sync2_q;
    logic             lock_s;

    assign lock_s = sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stable_q    <= '0;
            retry_q     <= '0;
            exhaust_q   <= 1'b0;
            lock_lost_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            exhaust_q   <= exhaust_d;
            lock_lost_q <= lock_lost_d;
            sync1_q     <= bus.pll_lock;
            sync2_q     <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (bus.start) state_d = StPorWait;
            StPorWait:  if (cnt_q == PorLast) state_d = StCdceRun;
            StCdceRun: begin
                if (bus.cdce_done)              state_d = StLockWait;
                else if (cnt_q == TimeoutLast)  state_d = StRetry;
            end
            StLockWait: begin
                if (lock_s && stable_q == StableLast) state_d = StAfeRun;
                else if (cnt_q == TimeoutLast)        state_d = StRetry;
            end
            StAfeRun: begin
                if (bus.afe_done)               state_d = StDone;
                else if (cnt_q == TimeoutLast)  state_d = StRetry;
            end
            StRetry: begin
                if (exhaust_q)                  state_d = StError;
                else if (cnt_q == HoldLast)     state_d = StCdceRun;
            end
            StDone:     state_d = StDone;
            StError:    state_d = StError;
            default:    state_d = StIdle;
        endcase
    end

    // Terminal/idle states freeze the cycle counter so it can never wrap.
    always_comb begin
        cnt_d       = cnt_q;
        stable_d    = '0;
        retry_d     = retry_q;
        exhaust_d   = exhaust_q;
        lock_lost_d = lock_lost_q;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != StIdle && state_q != StDone && state_q != StError) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (state_q == StLockWait && state_d == StLockWait && lock_s) begin
            stable_d = stable_q + 1'b1;
        end

        // Exhaustion is judged on the count held before this entry.
        if (state_d == StRetry && state_q != StRetry) begin
            exhaust_d = (retry_q == MaxRetry);
            if (retry_q != MaxRetry) retry_d = retry_q + 2'd1;
        end

        if (state_q == StDone && !lock_s) lock_lost_d = 1'b1;
    end

    always_comb begin
        bus.cdce_enable  = 1'b0;
        bus.cdce_reset_n = 1'b0;
        bus.afe_enable   = 1'b0;
        bus.afe_reset_n  = 1'b0;
        bus.config_done  = 1'b0;
        bus.config_error = 1'b0;
        case (state_q)
            StCdceRun: begin
                bus.cdce_enable  = 1'b1;
                bus.cdce_reset_n = 1'b1;
            end
            StLockWait: bus.cdce_reset_n = 1'b1;
            StAfeRun: begin
                bus.cdce_reset_n = 1'b1;
                bus.afe_reset_n  = 1'b1;
                bus.afe_enable   = 1'b1;
            end
            StDone: begin
                bus.cdce_reset_n = 1'b1;
                bus.afe_reset_n  = 1'b1;
                bus.config_done  = 1'b1;
            end
            StError:  bus.config_error = 1'b1;
            default: ;
        endcase
    end

    assign bus.lock_lost   = lock_lost_q;
    assign bus.retry_count = retry_q;
    assign bus.state_dbg   = state_q;

endmodule
